// File: rtl/gpu_pix_pkg.sv
// Shared pixel-path types and helpers for the palette/compositor datapath.
// Default widths match RGB888 with 4-bit palette alpha.
package gpu_pix_pkg;

    localparam int CH_W_DEF    = 8;
    localparam int ALPHA_W_DEF = 4;

    typedef struct packed {
        logic [CH_W_DEF-1:0] r;
        logic [CH_W_DEF-1:0] g;
        logic [CH_W_DEF-1:0] b;
    } rgb_t;

    // Maps alpha 0..2^aw-1 onto weight 0..2^aw so all-ones is fully opaque.
    function automatic logic [15:0] alpha_weight(input logic [15:0] a, input int unsigned aw);
        return a + (a >> (aw - 1));
    endfunction

endpackage

// File: rtl/layer_blend_stage.sv
// Purpose: one compositing stage, blends a layer over the running accumulator (LAYER_COMPOSITOR_ADDITIVE_EN adds saturating glow).
// Latency: 1 enabled tick, registered accumulator and video-active flag.
// Backpressure: none; all state holds when en is low.
module layer_blend_stage
    import gpu_pix_pkg::*;
#(
    parameter int CH_W    = CH_W_DEF,
    parameter int ALPHA_W = ALPHA_W_DEF,
    parameter int LAST    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [3*CH_W-1:0]    dst_rgb,
    input  logic                 dst_vid,
    input  logic [3*CH_W-1:0]    src_rgb,
    input  logic [ALPHA_W-1:0]   src_alpha,
`ifdef LAYER_COMPOSITOR_ADDITIVE_EN
    input  logic                 src_additive,
`endif
    output logic [3*CH_W-1:0]    acc_rgb,
    output logic                 acc_vid
);

    localparam int WW = ALPHA_W + 1;
    localparam int PW = CH_W + ALPHA_W + 1;

    logic [ALPHA_W-1:0] a_eff;
    logic [WW-1:0]      w;
    logic [WW-1:0]      w_inv;
    logic [3*CH_W-1:0]  blended;

    // Blanked pixels never take layer colour, only the background path.
    assign a_eff = dst_vid ? src_alpha : '0;
    assign w     = WW'(alpha_weight(16'(a_eff), ALPHA_W));
    assign w_inv = WW'(2 ** ALPHA_W) - w;

    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic [CH_W-1:0] s;
        logic [CH_W-1:0] d;
        logic [PW-1:0]   ps;
        logic [PW-1:0]   pd;
        logic [PW-1:0]   sum;

        assign s   = src_rgb[c*CH_W +: CH_W];
        assign d   = dst_rgb[c*CH_W +: CH_W];
        assign ps  = PW'(s) * PW'(w);
        assign pd  = PW'(d) * PW'(w_inv);
        assign sum = ps + pd;
`ifdef LAYER_COMPOSITOR_ADDITIVE_EN
        logic [CH_W:0] glow;
        assign glow = (CH_W+1)'(d) + (CH_W+1)'(ps >> ALPHA_W);
        assign blended[c*CH_W +: CH_W] = src_additive ? (glow[CH_W] ? {CH_W{1'b1}} : CH_W'(glow))
                                                      : CH_W'(sum >> ALPHA_W);
`else
        assign blended[c*CH_W +: CH_W] = CH_W'(sum >> ALPHA_W);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_rgb <= '0;
            acc_vid <= 1'b0;
        end else if (en) begin
            acc_vid <= dst_vid;
            acc_rgb <= (LAST != 0 && !dst_vid) ? '0 : blended;
        end
    end

endmodule

// File: rtl/layer_alpha_compositor.sv
// Purpose: back-to-front alpha compositing of NUM_LAYERS layers over bg_rgb (LAYER_COMPOSITOR_ADDITIVE_EN adds layer_additive).
// Latency: NUM_LAYERS+1 enabled ticks (pc_ena_in==0), one pixel per enabled tick.
// Backpressure: none; every register holds while pc_ena_in!=0.
module layer_alpha_compositor
    import gpu_pix_pkg::*;
#(
    parameter int NUM_LAYERS = 5,
    parameter int CH_W       = CH_W_DEF,
    parameter int ALPHA_W    = ALPHA_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [3:0]                    pc_ena_in,
    input  logic [NUM_LAYERS*3*CH_W-1:0]  layer_rgb,
    input  logic [NUM_LAYERS*ALPHA_W-1:0] layer_alpha,
    input  logic [NUM_LAYERS-1:0]         layer_ena,
`ifdef LAYER_COMPOSITOR_ADDITIVE_EN
    input  logic [NUM_LAYERS-1:0]         layer_additive,
`endif
    input  logic                          vid_active_in,
    input  logic [3*CH_W-1:0]             bg_rgb,
    output logic [CH_W-1:0]               pixel_out_r,
    output logic [CH_W-1:0]               pixel_out_g,
    output logic [CH_W-1:0]               pixel_out_b,
    output logic                          vid_active_out
);

    localparam int PIX_W = 3 * CH_W;
`ifdef LAYER_COMPOSITOR_ADDITIVE_EN
    localparam int LW = PIX_W + ALPHA_W + 1;
`else
    localparam int LW = PIX_W + ALPHA_W;
`endif

    logic en;
    assign en = (pc_ena_in == 4'd0);

    logic [PIX_W-1:0]   d_rgb   [NUM_LAYERS];
    logic [ALPHA_W-1:0] d_alpha [NUM_LAYERS];
`ifdef LAYER_COMPOSITOR_ADDITIVE_EN
    logic               d_add   [NUM_LAYERS];
`endif

    // Each layer is captured alongside bg at stage 0, then skewed so stage k
    // (which consumes layer NUM_LAYERS-k) sees the same pixel as its accumulator.
    for (genvar j = 0; j < NUM_LAYERS; j++) begin : g_skew
        localparam int D = NUM_LAYERS - 1 - j;

        logic [ALPHA_W-1:0] a_msk;
        logic [LW-1:0]      lin;
        logic [LW-1:0]      pipe [D+1];

        assign a_msk = layer_ena[j] ? layer_alpha[j*ALPHA_W +: ALPHA_W] : '0;
`ifdef LAYER_COMPOSITOR_ADDITIVE_EN
        assign lin = {layer_additive[j], a_msk, layer_rgb[j*PIX_W +: PIX_W]};
`else
        assign lin = {a_msk, layer_rgb[j*PIX_W +: PIX_W]};
`endif

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int i = 0; i <= D; i++) pipe[i] <= '0;
            end else if (en) begin
                pipe[0] <= lin;
                for (int i = 1; i <= D; i++) pipe[i] <= pipe[i-1];
            end
        end

        assign d_rgb[j]   = pipe[D][PIX_W-1:0];
        assign d_alpha[j] = pipe[D][PIX_W +: ALPHA_W];
`ifdef LAYER_COMPOSITOR_ADDITIVE_EN
        assign d_add[j]   = pipe[D][LW-1];
`endif
    end

    logic [PIX_W-1:0] acc [NUM_LAYERS+1];
    logic             vid [NUM_LAYERS+1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc[0] <= '0;
            vid[0] <= 1'b0;
        end else if (en) begin
            acc[0] <= bg_rgb;
            vid[0] <= vid_active_in;
        end
    end

    for (genvar k = 1; k <= NUM_LAYERS; k++) begin : g_stage
        layer_blend_stage #(
            .CH_W    (CH_W),
            .ALPHA_W (ALPHA_W),
            .LAST    ((k == NUM_LAYERS) ? 1 : 0)
        ) u_stage (
            .clk          (clk),
            .rst_n        (rst_n),
            .en           (en),
            .dst_rgb      (acc[k-1]),
            .dst_vid      (vid[k-1]),
            .src_rgb      (d_rgb[NUM_LAYERS-k]),
            .src_alpha    (d_alpha[NUM_LAYERS-k]),
`ifdef LAYER_COMPOSITOR_ADDITIVE_EN
            .src_additive (d_add[NUM_LAYERS-k]),
`endif
            .acc_rgb      (acc[k]),
            .acc_vid      (vid[k])
        );
    end

    assign pixel_out_r    = acc[NUM_LAYERS][PIX_W-1 -: CH_W];
    assign pixel_out_g    = acc[NUM_LAYERS][PIX_W-1-CH_W -: CH_W];
    assign pixel_out_b    = acc[NUM_LAYERS][CH_W-1:0];
    assign vid_active_out = vid[NUM_LAYERS];

endmodule

// File: doc/layer_alpha_compositor.md
Name: layer_alpha_compositor

Overview:
- Parametrised successor to the priority-mux palette mixer. Takes NUM_LAYERS post-palette RGB888 + 4-bit alpha layer streams and produces one RGB888 output pixel.
- Replaces first-opaque-layer selection with true back-to-front alpha compositing over a programmable background colour.
- One pipeline stage per layer; advances only on pixel-clock-enable ticks.
- Sits between the palette RAM outputs and the video output/HDMI encoder.

Parameters:
- NUM_LAYERS, 5, number of composited layers (1..15); layer 0 is frontmost.
- CH_W, 8, bits per colour channel.
- ALPHA_W, 4, alpha width; alpha all-ones = opaque, 0 = transparent.

Ports:
- clk  in  1  primary pixel-domain clock.
- rst_n  in  1  synchronous active-low reset.
- pc_ena_in  in  4  pixel clock enable phase; pipeline advances only when pc_ena_in==0.
- layer_rgb  in  NUM_LAYERS x 3*CH_W  per-layer RGB, packed {r,g,b}.
- layer_alpha  in  NUM_LAYERS x ALPHA_W  per-layer alpha from the palette stage.
- layer_ena  in  NUM_LAYERS  per-layer enable; 0 forces that layer's alpha to 0.
- vid_active_in  in  1  video active flag aligned with layer inputs.
- bg_rgb  in  3*CH_W  background colour, sampled at stage 0.
- pixel_out_r / pixel_out_g / pixel_out_b  out  CH_W each  composited pixel.
- vid_active_out  out  1  vid_active_in delayed to match the pixel outputs.

Behaviour:
- Reset (rst_n=0 at a clk edge): all skew, pipeline and output registers clear to 0. Outputs read 0 on the next cycle. Applies mid-frame or mid-pipeline; the pipeline refills from bg with no stale data.
- Enable: on a clk edge with pc_ena_in!=0, every register holds. All stages and skew registers shift together only when pc_ena_in==0.
- Stage 0 latches bg_rgb as the accumulator. Stage k (k=1..NUM_LAYERS) blends layer NUM_LAYERS-k over the accumulator.
- Skew buffers: layer j input is delayed by NUM_LAYERS-1-j enabled ticks, so every stage sees data from the same pixel. vid_active_in has a matching delay.
- Latency: NUM_LAYERS+1 enabled ticks from input to pixel_out_*. Throughput: one pixel per enabled tick.
- Weight: w = a + (a >> (ALPHA_W-1)), range 0..2^ALPHA_W. For ALPHA_W=4: a=15 -> w=16, a=8 -> w=9, a=0 -> w=0.
- Per-channel blend: out = (src*w + dst*(2^ALPHA_W - w)) >> ALPHA_W. Intermediate width is CH_W+ALPHA_W+1. The shift truncates with no rounding, so a=15 passes src exactly and a=0 passes dst exactly.
- Effective alpha is 0 when layer_ena[j]=0 or the delayed vid_active for that pixel is 0.
- Final register: if delayed vid_active=0, the outputs are forced to 0 (black), regardless of bg_rgb.
- An identical input held constant yields a stable output with no drift or accumulation across ticks.
- Parameter edge case: NUM_LAYERS=1 has no skew registers and latency 2.

Optional Feature:
- Macro LAYER_COMPOSITOR_ADDITIVE_EN.
- Defined: adds input port layer_additive (NUM_LAYERS bits). When set for a layer, that stage computes out = min(dst + ((src*w) >> ALPHA_W), 2^CH_W - 1) per channel (saturating glow/light mode). When clear, normal blend applies.
- Undefined: the port is absent and every layer uses normal blend. No saturation logic is synthesised.

Decomposition:
- Shared package gpu_pix_pkg:
  - typedef rgb_t (struct of r, g, b, each CH_W);
  - constants CH_W_DEF=8, ALPHA_W_DEF=4;
  - function alpha_weight(a).
- Sub-module layer_blend_stage: one pipeline stage holding the weight calc, per-channel multiply/blend and optional additive saturate, plus the registered accumulator and delayed vid_active. The top level instantiates NUM_LAYERS of them via generate, plus the skew registers.

Test Plan:
- Reset/latency: NUM_LAYERS=5, pc_ena_in cycling 0..3, bg=0x102030, all alpha 0, vid_active=1 -> output 0x102030 exactly 6 enabled ticks after first valid input. rst_n=0 mid-stream -> outputs 0 next cycle, refilled after 6 ticks.
- Opaque priority: layer0=0xFF0000 a=15, layer2=0x00FF00 a=15 -> output 0xFF0000. Then set layer0 alpha 0 -> output 0x00FF00.
- Half blend: single layer 0xFF0000 a=8 over bg 0x0000FF -> w=9, R=(255*9)>>4=143 (0x8F), B=(255*7)>>4=111 (0x6F), G=0.
- Masking/blanking: layer_ena[0]=0 with layer0 opaque red over bg 0x0000FF -> 0x0000FF. Any pixel with vid_active_in=0 -> output 0 and vid_active_out=0, aligned.
- Stall: hold pc_ena_in=2 for 10 cycles mid-stream -> outputs and vid_active_out frozen. Resume -> sequence continues with no dropped or duplicated pixel.
- Additive (macro defined): bg 0xC0C0C0, layer 0x808080 a=15 additive -> 0xFFFFFF saturated. Same pixel with additive bit clear -> 0x808080.
